// File: rtl/sonar_timestamp_fmt_pkg.sv
// Shared types and lookup tables for the sonar timestamp formatter.
package sonar_ts_pkg;

  typedef enum logic [1:0] {
    OP_INIT  = 2'd0,
    OP_PRINT = 2'd1,
    OP_REL   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    UNIT_PS = 2'd0,
    UNIT_NS = 2'd1,
    UNIT_US = 2'd2,
    UNIT_MS = 2'd3
  } unit_e;

  // 10^prec for the fractional digit count
  localparam logic [9:0] POW10 [4] = '{10'd1, 10'd10, 10'd100, 10'd1000};

  // picoseconds per selected unit, 10^(3*unit)
  localparam logic [63:0] DIV_LUT [4] = '{64'd1, 64'd1000, 64'd1000000, 64'd1000000000};

endpackage

// File: rtl/sonar_timestamp_fmt_div.sv
// Restoring unsigned divider. The start cycle already performs the first
// quotient step on the freshly presented operands, so results are ready
// (done pulses) exactly W cycles after start; quotient/remainder hold
// until the next start.
module seq_divider_u #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  logic [W-1:0]  step_quo;
  logic [W-1:0]  step_rem;
  logic [W-1:0]  step_div;
  logic [W:0]    trial;
  logic          fits;

  // one shift-subtract step, on new operands at start or on running state otherwise
  always_comb begin
    step_quo = start ? dividend : quo_q;
    step_rem = start ? '0 : rem_q;
    step_div = start ? divisor : div_q;
    trial    = {step_rem, step_quo[W-1]};
    fits     = (trial >= {1'b0, step_div});
  end

  // iteration control and next-state of the partial remainder/quotient
  always_comb begin
    quo_d    = quo_q;
    rem_d    = rem_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (start || active_q) begin
      quo_d = {step_quo[W-2:0], fits};
      rem_d = fits ? (trial[W-1:0] - step_div) : trial[W-1:0];
    end
    if (start) begin
      div_d    = divisor;
      cnt_d    = CW'(W - 1);
      active_d = 1'b1;
    end else if (active_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/sonar_timestamp_fmt.sv
// Timestamp formatter: free-running cycle counter scaled to picoseconds,
// reported absolute or relative to a captured reference, split into an
// integer part in the chosen unit and a truncated decimal fraction.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   S_IDLE     | ready for a command; INIT / reserved handled in place
//   S_DIV_INT  | divider computing v / D
//   S_DIV_FRAC | divider computing (v % D) * 10^prec / D
//   S_DONE     | result presented, waiting for out_ready
module sonar_timestamp_fmt
  import sonar_ts_pkg::*;
#(
  parameter int CLK_PERIOD_PS = 10000,
  parameter int TIME_W        = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        fmt_unit,
  input  logic [1:0]        fmt_prec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TIME_W-1:0] out_int,
  output logic [9:0]        out_frac,
  output logic              out_rel
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DIV_INT  = 2'd1;
  localparam logic [1:0] S_DIV_FRAC = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [TIME_W-1:0] PERIOD = TIME_W'(CLK_PERIOD_PS);

  logic [TIME_W-1:0] cyc_q, cyc_d;
  logic [TIME_W-1:0] ref_q, ref_d;
  logic [1:0]        state_q, state_d;
  logic [1:0]        unit_q, unit_d;
  logic [1:0]        prec_q, prec_d;
  logic [TIME_W-1:0] out_int_q, out_int_d;
  logic [9:0]        out_frac_q, out_frac_d;
  logic              out_rel_q, out_rel_d;
  logic              out_valid_q, out_valid_d;

  logic [TIME_W-1:0] now_ps;
  logic [TIME_W-1:0] v_sel;
  op_e               op;
  logic              accept;

  logic              div_start;
  logic              div_done;
  logic [TIME_W-1:0] div_dividend;
  logic [TIME_W-1:0] div_divisor;
  logic [TIME_W-1:0] div_quo;
  logic [TIME_W-1:0] div_rem;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign now_ps    = cyc_q * PERIOD;
  assign v_sel     = (op == OP_REL) ? (now_ps - ref_q) : now_ps;

  // command decode, divider sequencing and result capture
  always_comb begin
    cyc_d        = cyc_q + 1'b1;
    ref_d        = ref_q;
    state_d      = state_q;
    unit_d       = unit_q;
    prec_d       = prec_q;
    out_int_d    = out_int_q;
    out_frac_d   = out_frac_q;
    out_rel_d    = out_rel_q;
    out_valid_d  = out_valid_q;
    div_start    = 1'b0;
    div_dividend = v_sel;
    div_divisor  = TIME_W'(DIV_LUT[fmt_unit]);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_INIT: ref_d = now_ps;
            OP_PRINT, OP_REL: begin
              unit_d    = fmt_unit;
              prec_d    = fmt_prec;
              out_rel_d = (op == OP_REL);
              if (fmt_unit == UNIT_PS) begin
                out_int_d   = v_sel;
                out_frac_d  = '0;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
              end else begin
                div_start = 1'b1;
                state_d   = S_DIV_INT;
              end
            end
            default: ;
          endcase
        end
      end
      S_DIV_INT: begin
        // out_int is free to take the quotient early: out_valid is low here
        div_dividend = div_rem * TIME_W'(POW10[prec_q]);
        div_divisor  = TIME_W'(DIV_LUT[unit_q]);
        if (div_done) begin
          out_int_d = div_quo;
          div_start = 1'b1;
          state_d   = S_DIV_FRAC;
        end
      end
      S_DIV_FRAC: begin
        if (div_done) begin
          out_frac_d  = div_quo[9:0];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  // state registers; reset also aborts any conversion and clears the reference
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q       <= '0;
      ref_q       <= '0;
      state_q     <= S_IDLE;
      unit_q      <= '0;
      prec_q      <= '0;
      out_int_q   <= '0;
      out_frac_q  <= '0;
      out_rel_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cyc_q       <= cyc_d;
      ref_q       <= ref_d;
      state_q     <= state_d;
      unit_q      <= unit_d;
      prec_q      <= prec_d;
      out_int_q   <= out_int_d;
      out_frac_q  <= out_frac_d;
      out_rel_q   <= out_rel_d;
      out_valid_q <= out_valid_d;
    end
  end

  seq_divider_u #(.W(TIME_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign out_valid = out_valid_q;
  assign out_int   = out_int_q;
  assign out_frac  = out_frac_q;
  assign out_rel   = out_rel_q;

endmodule

// File: tb/tb_sonar_timestamp_fmt.sv
// Bench for sonar_timestamp_fmt: fixed vector table, hand-written corner
// sequences, then random commands checked against an arithmetic model.
`timescale 1ns/1ps
module tb_sonar_timestamp_fmt;

  localparam int PER = 10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  fmt_unit = 2'd0;
  logic [1:0]  fmt_prec = 2'd0;
  logic        cmd_ready;
  logic        out_valid;
  logic        out_rel;
  logic [63:0] out_int;
  logic [9:0]  out_frac;

  sonar_timestamp_fmt #(.CLK_PERIOD_PS(PER), .TIME_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .fmt_unit  (fmt_unit),
    .fmt_prec  (fmt_prec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_frac  (out_frac),
    .out_rel   (out_rel)
  );

  always #5 clk = ~clk;

  // bench's own view of the cycle count: zero after a reset edge, +1 otherwise
  logic [63:0] tb_cyc;
  always @(posedge clk) begin
    if (rst) tb_cyc <= 64'd0;
    else     tb_cyc <= tb_cyc + 64'd1;
  end

  int          n_err = 0;
  int          n_chk = 0;
  logic [63:0] ref_ps_m = 64'd0;

  typedef struct {
    bit          pre_rst;
    int          cyc;
    logic [1:0]  op;
    logic [1:0]  unit;
    logic [1:0]  prec;
    logic [63:0] ei;
    logic [63:0] ef;
    logic        er;
    int          lat;
    bit          has_out;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(bit pr, int c, int op, int u, int p,
                              longint ei, longint ef, bit er, int lat, bit ho);
    vec_t v;
    v.pre_rst = pr;
    v.cyc     = c;
    v.op      = 2'(op);
    v.unit    = 2'(u);
    v.prec    = 2'(p);
    v.ei      = 64'(ei);
    v.ef      = 64'(ef);
    v.er      = er;
    v.lat     = lat;
    v.has_out = ho;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference: time in ps scaled by plain division, fraction from the remainder
  function automatic void model(input logic [1:0] op, input logic [1:0] unit,
                                input logic [1:0] prec, input logic [63:0] acc,
                                output logic [63:0] ei, output logic [63:0] ef,
                                output logic er);
    logic [63:0] now, v, d, p;
    now = acc * 64'(PER);
    v   = (op == 2'd2) ? now - ref_ps_m : now;
    d   = 64'd1;
    for (int i = 0; i < int'(unit); i++) d = d * 64'd1000;
    p   = 64'd1;
    for (int i = 0; i < int'(prec); i++) p = p * 64'd10;
    ei  = v / d;
    ef  = ((v % d) * p) / d;
    er  = (op == 2'd2);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    ref_ps_m  = 64'd0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rst_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_rst_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_rst_int"},   out_int, 64'd0);
    chk({tag, "_rst_frac"},  64'(out_frac), 64'd0);
    chk({tag, "_rst_rel"},   64'(out_rel), 64'd0);
  endtask

  // target < 0 issues at the next negedge; otherwise in the cycle with cyc == target
  task automatic issue(input int target, input logic [1:0] op, input logic [1:0] unit,
                       input logic [1:0] prec, output logic [63:0] acc);
    int guard;
    guard = 0;
    @(negedge clk);
    if (target >= 0) begin
      while (tb_cyc < 64'(target) && guard < 30000) begin
        @(negedge clk);
        guard++;
      end
      chk("issue_cycle", tb_cyc, 64'(target));
    end
    cmd_op    = op;
    fmt_unit  = unit;
    fmt_prec  = prec;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    acc = tb_cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (op == 2'd0) ref_ps_m = acc * 64'(PER);
  endtask

  task automatic wait_result(input string name, input logic [63:0] acc, input int exp_lat,
                             input logic [63:0] ei, input logic [63:0] ef, input logic er,
                             input int hold);
    int guard;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_lat"},   tb_cyc - acc, 64'(exp_lat));
    chk({name, "_int"},   out_int, ei);
    chk({name, "_frac"},  64'(out_frac), ef);
    chk({name, "_rel"},   64'(out_rel), 64'(er));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_hold_ready"}, 64'(cmd_ready), 64'd0);
      chk({name, "_hold_int"},   out_int, ei);
      chk({name, "_hold_frac"},  64'(out_frac), ef);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({name, "_drop_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_ready_again"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic no_output(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] acc, ei, ef;
    logic        er;
    int          lat;
    logic [1:0]  op, unit, prec;

    //            rst  cyc    op u  p  int        frac er lat has_out
    tbl[0]  = mk(1,   5,     1, 1, 0, 50,        0,   0, 129, 1);
    tbl[1]  = mk(1,   10,    0, 0, 0, 0,         0,   0, 0,   0);
    tbl[2]  = mk(0,   25,    2, 2, 3, 0,         150, 1, 129, 1);
    tbl[3]  = mk(0,   300,   1, 1, 3, 3000,      0,   0, 129, 1);
    tbl[4]  = mk(0,   500,   2, 1, 1, 4900,      0,   1, 129, 1);
    tbl[5]  = mk(0,   777,   2, 2, 2, 7,         67,  1, 129, 1);
    tbl[6]  = mk(0,   12345, 1, 2, 2, 123,       45,  0, 129, 1);
    tbl[7]  = mk(0,   12600, 1, 3, 3, 0,         126, 0, 129, 1);
    tbl[8]  = mk(0,   12900, 2, 2, 0, 128,       0,   1, 129, 1);
    tbl[9]  = mk(0,   13200, 1, 0, 2, 132000000, 0,   0, 1,   1);
    tbl[10] = mk(0,   13300, 3, 1, 1, 0,         0,   0, 0,   0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].pre_rst) begin
        do_reset();
        check_reset_state($sformatf("vec%0d", i));
      end
      issue(tbl[i].cyc, tbl[i].op, tbl[i].unit, tbl[i].prec, acc);
      if (tbl[i].has_out)
        wait_result($sformatf("vec%0d", i), acc, tbl[i].lat, tbl[i].ei, tbl[i].ef, tbl[i].er, 0);
      else
        no_output($sformatf("vec%0d_noout", i), 10);
    end

    // ps unit: one-cycle latency, result held while the consumer stalls
    do_reset();
    issue(7, 2'd1, 2'd0, 2'd3, acc);
    wait_result("ps_hold", acc, 1, 64'd70000, 64'd0, 1'b0, 5);

    // reset during DIV_INT aborts and clears the reference
    do_reset();
    issue(4, 2'd0, 2'd0, 2'd0, acc);
    issue(6, 2'd1, 2'd1, 2'd0, acc);
    while (tb_cyc < 64'd30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_ps_m = 64'd0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    issue(40, 2'd2, 2'd2, 2'd3, acc);
    wait_result("rel_after_rst", acc, 129, 64'd0, 64'd400, 1'b1, 0);

    // command pulsed while busy is refused and yields no extra result
    issue(200, 2'd1, 2'd1, 2'd2, acc);
    while (tb_cyc < 64'd210) @(negedge clk);
    cmd_op    = 2'd1;
    fmt_unit  = 2'd2;
    cmd_valid = 1'b1;
    chk("busy_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_result("busy_main", acc, 129, 64'd2000, 64'd0, 1'b0, 0);
    no_output("busy_no_extra", 150);

    // random commands against the model
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      op   = 2'($urandom_range(0, 3));
      unit = 2'($urandom_range(0, 3));
      prec = 2'($urandom_range(0, 3));
      model(op, unit, prec, tb_cyc + 64'd1, ei, ef, er);
      issue(-1, op, unit, prec, acc);
      if (op == 2'd1 || op == 2'd2) begin
        model(op, unit, prec, acc, ei, ef, er);
        lat = (unit == 2'd0) ? 1 : 129;
        wait_result($sformatf("rnd%0d", k), acc, lat, ei, ef, er, $urandom_range(0, 3));
      end else begin
        no_output($sformatf("rnd%0d_noout", k), 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
